// File: rtl/phys_free_list_if.sv
// phys_free_list_if
//   Bundles the rename/commit side of the physical register free list.
//   master : rename + commit logic (drives requests, frees, commits, flush)
//   slave  : phys_free_list (returns grant, register number and status)
//
//   Handshake: Alloc_req/Alloc_grant is a same-cycle valid/ready pair.
//   Rename raises Alloc_req when it needs a destination. The list answers
//   combinationally with Alloc_grant, and Alloc_preg carries the register.
//   A transfer happens on a rising edge where both are high. Alloc_preg is
//   meaningful only when Alloc_grant is high. Free_valid, Commit_alloc and
//   Flush are fire-and-forget strobes that are always accepted. A Free_valid
//   arriving while the list is full is dropped and recorded in Overflow.
//
//   Signals:
//     Alloc_req    m->s  rename needs a destination register this cycle
//     Alloc_grant  s->m  allocation accepted this cycle
//     Alloc_preg   s->m  register at the speculative head
//     Free_valid   m->s  commit returns a register
//     Free_preg    m->s  register being returned
//     Commit_alloc m->s  oldest speculative allocation becomes committed
//     Flush        m->s  discard all speculative allocations
//     Empty        s->m  no speculatively free registers left
//     Free_count   s->m  speculatively free register count
//     Overflow     s->m  sticky: a free arrived while the list was full
interface phys_free_list_if #(
  parameter int NUM_ARCH_REGS = 35,
  parameter int NUM_PHYS_REGS = 64
);
  localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS);
  localparam int DEPTH    = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic                Alloc_req;
  logic                Alloc_grant;
  logic [LOG_PHYS-1:0] Alloc_preg;
  logic                Free_valid;
  logic [LOG_PHYS-1:0] Free_preg;
  logic                Commit_alloc;
  logic                Flush;
  logic                Empty;
  logic [CNT_W-1:0]    Free_count;
  logic                Overflow;

  modport master (
    output Alloc_req, Free_valid, Free_preg, Commit_alloc, Flush,
    input  Alloc_grant, Alloc_preg, Empty, Free_count, Overflow
  );

  modport slave (
    input  Alloc_req, Free_valid, Free_preg, Commit_alloc, Flush,
    output Alloc_grant, Alloc_preg, Empty, Free_count, Overflow
  );
endinterface

// File: rtl/phys_free_list.sv
// phys_free_list
//   Circular free list of physical register numbers for the rename stage.
//   It offers the register at the speculative head every cycle. Commit
//   returns registers at the tail. A second, committed head pointer marks
//   how far allocation has become non-speculative, so a flush can rewind
//   the speculative head in a single cycle.
//
//   Ports:
//     CLK    clock, all state updates on the rising edge
//     RESET  synchronous, active-low; wins over every other input
//     fl     phys_free_list_if.slave (alloc / free / commit / flush / status)
//
//   The list holds DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS entries. DEPTH need
//   not be a power of two, so every pointer wraps explicitly at DEPTH-1.
module phys_free_list #(
  parameter int NUM_ARCH_REGS = 35,
  parameter int NUM_PHYS_REGS = 64
) (
  input logic             CLK,
  input logic             RESET,
  phys_free_list_if.slave fl
);
  localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS);
  localparam int DEPTH    = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W    = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Storage and pointers
  logic [LOG_PHYS-1:0] entry_q [DEPTH];
  logic [PTR_W-1:0]    spec_head_q, commit_head_q, tail_q;
  logic [CNT_W-1:0]    spec_count_q, commit_count_q;
  logic                overflow_q;

  // Next-state values
  logic [PTR_W-1:0]    spec_head_d, commit_head_d, tail_d;
  logic [CNT_W-1:0]    spec_count_d, commit_count_d;
  logic                overflow_d;
  logic                grant;
  logic                free_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_ONE;
  endfunction

  always_comb begin
    // A free never feeds a same-cycle allocation. The grant looks only at
    // the registered count, and a flush cycle never grants because the head
    // is being rewound.
    grant   = fl.Alloc_req & (spec_count_q != '0) & ~fl.Flush;
    // Fullness is judged on the committed count. Registers that were
    // allocated speculatively still occupy their slots until they commit.
    free_ok = fl.Free_valid & (commit_count_q != FULL_CNT);

    commit_head_d  = commit_head_q;
    commit_count_d = commit_count_q;
    tail_d         = tail_q;
    overflow_d     = overflow_q;

    if (free_ok) begin
      tail_d         = ptr_inc(tail_q);
      commit_count_d = commit_count_d + CNT_ONE;
    end else if (fl.Free_valid) begin
      overflow_d = 1'b1;
    end

    // Commit_alloc with commit_count == 0 is a producer error and is not
    // guarded here.
    if (fl.Commit_alloc) begin
      commit_head_d  = ptr_inc(commit_head_q);
      commit_count_d = commit_count_d - CNT_ONE;
    end

    spec_head_d  = spec_head_q;
    spec_count_d = spec_count_q;
    if (fl.Flush) begin
      // Rewind to the committed view. Same-cycle frees and commits are
      // folded in through the *_d values.
      spec_head_d  = commit_head_d;
      spec_count_d = commit_count_d;
    end else begin
      if (grant) begin
        spec_head_d  = ptr_inc(spec_head_q);
        spec_count_d = spec_count_d - CNT_ONE;
      end
      if (free_ok) begin
        spec_count_d = spec_count_d + CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      spec_head_q    <= '0;
      commit_head_q  <= '0;
      tail_q         <= '0;
      spec_count_q   <= FULL_CNT;
      commit_count_q <= FULL_CNT;
      overflow_q     <= 1'b0;
    end else begin
      spec_head_q    <= spec_head_d;
      commit_head_q  <= commit_head_d;
      tail_q         <= tail_d;
      spec_count_q   <= spec_count_d;
      commit_count_q <= commit_count_d;
      overflow_q     <= overflow_d;
    end
  end

  // Registers beyond the architectural set start out free, in ascending order.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= LOG_PHYS'(NUM_ARCH_REGS + i);
      end
    end else if (free_ok) begin
      entry_q[tail_q] <= fl.Free_preg;
    end
  end

  assign fl.Alloc_grant = grant;
  assign fl.Alloc_preg  = entry_q[spec_head_q];
  assign fl.Empty       = (spec_count_q == '0);
  assign fl.Free_count  = spec_count_q;
  assign fl.Overflow    = overflow_q;

endmodule

// File: tb/tb_phys_free_list.sv
// tb_phys_free_list
//   Bench for phys_free_list. It runs a hand-derived vector table, directed
//   corner sequences, and random traffic checked against a queue model.
module tb_phys_free_list;
  localparam int DEPTH = 29;
  localparam int FIRST = 35;

  // Clock and reset
  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  phys_free_list_if fl ();
  phys_free_list dut (.CLK(CLK), .RESET(RESET), .fl(fl));

  int n_vec;
  int n_err;

  // Reference model. m_q holds the registers from the committed head to the
  // tail. The first m_used of them are handed out speculatively.
  int m_q[$];
  int m_used;
  bit m_ovf;

  typedef struct {
    bit req; bit fv; int fp; bit ca; bit fls;
    bit e_grant; int e_preg; int e_cnt; bit e_empty; bit e_ovf;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = {};
    for (int i = 0; i < DEPTH; i++) m_q.push_back(FIRST + i);
    m_used = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic drive(input bit req, input bit fv, input int fp, input bit ca, input bit fls);
    fl.Alloc_req    = req;
    fl.Free_valid   = fv;
    fl.Free_preg    = 6'(fp);
    fl.Commit_alloc = ca;
    fl.Flush        = fls;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    RESET = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    model_reset();
  endtask

  // One cycle. Drive the inputs, compare against the model at the falling
  // edge, then advance the model across the rising edge.
  task automatic step(input bit req, input bit fv, input int fp, input bit ca, input bit fls);
    int cnt;
    bit g;
    bit free_ok;
    drive(req, fv, fp, ca, fls);
    @(negedge CLK);
    cnt = m_q.size() - m_used;
    g   = req && (cnt != 0) && !fls;
    check("model_grant", int'(fl.Alloc_grant), int'(g));
    if (g) check("model_preg", int'(fl.Alloc_preg), m_q[m_used]);
    check("model_count", int'(fl.Free_count), cnt);
    check("model_empty", int'(fl.Empty), int'(cnt == 0));
    check("model_ovf", int'(fl.Overflow), int'(m_ovf));
    @(posedge CLK);
    free_ok = fv && (m_q.size() < DEPTH);
    if (fv && !free_ok) m_ovf = 1'b1;
    if (ca) begin
      assert (m_q.size() > 0) else begin
        n_err++;
        $display("FAIL commit_legal: got commit with 0 committed entries, expected none");
      end
      if (m_q.size() > 0) void'(m_q.pop_front());
    end
    if (free_ok) m_q.push_back(fp & 63);
    m_used = m_used + int'(g) - int'(ca);
    if (fls) m_used = 0;
    #1;
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    bit req, fv, ca, fls;
    n_vec = 0;
    n_err = 0;

    //                 req fv fp ca fl | grant preg cnt empty ovf
    tbl[0]  = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 35, 29, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 36, 28, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 37, 27, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0,  0, 26, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0,  0, 26, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 36, 28, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 7, 1'b0, 1'b0, 1'b1, 37, 27, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b0,  0, 27, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 38, 27, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0,  0, 26, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 36, 29, 1'b0, 1'b1};

    do_reset();
    check("rst_count", int'(fl.Free_count), 29);
    check("rst_preg", int'(fl.Alloc_preg), 35);
    check("rst_empty", int'(fl.Empty), 0);
    check("rst_ovf", int'(fl.Overflow), 0);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].req, tbl[i].fv, tbl[i].fp, tbl[i].ca, tbl[i].fls);
      @(negedge CLK);
      check("tbl_grant", int'(fl.Alloc_grant), int'(tbl[i].e_grant));
      if (tbl[i].e_grant) check("tbl_preg", int'(fl.Alloc_preg), tbl[i].e_preg);
      check("tbl_count", int'(fl.Free_count), tbl[i].e_cnt);
      check("tbl_empty", int'(fl.Empty), int'(tbl[i].e_empty));
      check("tbl_ovf", int'(fl.Overflow), int'(tbl[i].e_ovf));
      @(posedge CLK);
      #1;
    end

    // Drain the whole list, then check the empty boundary
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0, 0, 0);
      #1;
      check("fill_grant", int'(fl.Alloc_grant), 1);
      check("fill_preg", int'(fl.Alloc_preg), FIRST + i);
      step(1, 0, 0, 0, 0);
    end
    check("fill_empty", int'(fl.Empty), 1);
    check("fill_count", int'(fl.Free_count), 0);
    drive(1, 0, 0, 0, 0);
    #1;
    check("fill_nogrant", int'(fl.Alloc_grant), 0);

    // A free does not bypass into a same-cycle allocation
    step(0, 0, 0, 1, 0);
    drive(1, 1, 5, 0, 0);
    #1;
    check("nobypass_grant", int'(fl.Alloc_grant), 0);
    step(1, 1, 5, 0, 0);
    drive(1, 0, 0, 0, 0);
    #1;
    check("freed_grant", int'(fl.Alloc_grant), 1);
    check("freed_preg", int'(fl.Alloc_preg), 5);
    step(1, 0, 0, 0, 0);

    // Pointer wrap past the last index
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0);
    for (int i = 1; i <= 10; i++) step(0, 1, i, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0, 0);
      #1;
      check("wrap_preg", int'(fl.Alloc_preg), i + 1);
      step(1, 0, 0, 0, 0);
    end
    check("wrap_count", int'(fl.Free_count), 0);

    // Free into a full list sets a sticky overflow
    do_reset();
    step(0, 1, 7, 0, 0);
    check("ovf_set", int'(fl.Overflow), 1);
    check("ovf_count", int'(fl.Free_count), 29);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    check("ovf_sticky", int'(fl.Overflow), 1);

    // Reset has priority over alloc, free and flush
    drive(1, 1, 3, 0, 1);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    check("midrst_count", int'(fl.Free_count), 29);
    check("midrst_preg", int'(fl.Alloc_preg), 35);
    check("midrst_ovf", int'(fl.Overflow), 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 750 == 0) do_reset();
      req = ($urandom_range(0, 3) != 0);
      fv  = (m_q.size() < DEPTH) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      ca  = (m_used > 0) && ($urandom_range(0, 2) == 0);
      fls = ($urandom_range(0, 19) == 0);
      step(req, fv, int'($urandom_range(0, 63)), ca, fls);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
